// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous-FIFO write port among N producers.
// Grants are held for up to MAX_BURST accepted beats and stall cleanly on FIFO full.
module fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       data_in,
    input  logic                 fifo_full,
    output logic [N-1:0]         gnt,
    output logic                 fifo_wr_en,
    output logic [W-1:0]         fifo_wr_data,
    output logic [$clog2(N)-1:0] owner_id,
    output logic                 busy
);

    localparam int IW = $clog2(N);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    gnt_nxt;
    logic [IW-1:0]   owner, owner_nxt;
    logic [IW-1:0]   last, last_nxt;
    logic [BW-1:0]   beat_cnt, beat_nxt;
    logic [IW-1:0]   pick_base, pick_idx;
    logic            pick_valid;
    logic            accept, release_now;

    // The search starts just after pick_base, so the base index itself is tried last.
    always_comb begin
        pick_base  = (state == BUSY) ? owner : last;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = N; i >= 1; i--) begin
            int cand;
            cand = (int'(pick_base) + i) % N;
            if (req[cand[IW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    assign busy        = (state == BUSY);
    assign accept      = busy & req[owner] & ~fifo_full;
    assign release_now = (accept && (beat_cnt == BW'(MAX_BURST - 1))) || !req[owner];
    assign fifo_wr_en  = accept;
    assign owner_id    = owner;

    always_comb begin
        fifo_wr_data = '0;
        for (int k = 0; k < N; k++) begin
            if (busy && (owner == IW'(k))) begin
                fifo_wr_data = data_in[k*W +: W];
            end
        end
    end

    // Next-state logic: a full-stall cycle leaves owner, grant and beat count untouched.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        owner_nxt = owner;
        last_nxt  = last;
        beat_nxt  = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = BUSY;
                    owner_nxt = pick_idx;
                    gnt_nxt   = N'(1) << pick_idx;
                    beat_nxt  = '0;
                end
            end
            BUSY: begin
                if (accept) begin
                    beat_nxt = beat_cnt + BW'(1);
                end
                if (release_now) begin
                    last_nxt = owner;
                    beat_nxt = '0;
                    if (pick_valid) begin
                        owner_nxt = pick_idx;
                        gnt_nxt   = N'(1) << pick_idx;
                    end else begin
                        state_nxt = IDLE;
                        owner_nxt = '0;
                        gnt_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                owner_nxt = '0;
                beat_nxt  = '0;
            end
        endcase
    end

    // Pointer resets to N-1 so producer 0 has first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            last     <= IW'(N - 1);
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            owner    <= owner_nxt;
            last     <= last_nxt;
            beat_cnt <= beat_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized checks of fifo_wr_arbiter against a round-robin burst model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req;
    logic [N*W-1:0]       data_in;
    logic                 fifo_full;
    logic [N-1:0]         gnt;
    logic                 fifo_wr_en;
    logic [W-1:0]         fifo_wr_data;
    logic [$clog2(N)-1:0] owner_id;
    logic                 busy;

    int n_cmp  = 0;
    int n_fail = 0;

    bit          m_busy;
    int          m_owner;
    int          m_beats;
    int          m_last;
    logic [W-1:0] prod_data [N];
    logic [W-1:0] obs_log [$];
    int           obs_own [$];

    fifo_wr_arbiter #(.N(N), .W(W), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .gnt          (gnt),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .owner_id     (owner_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic int rr_pick(input logic [N-1:0] r, input int after);
        for (int k = 1; k <= N; k++) begin
            if (r[(after + k) % N]) return (after + k) % N;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_beats = 0;
        m_last  = N - 1;
    endtask

    // Burst bookkeeping: m_beats counts completed writes in the current grant.
    task automatic modelStep();
        bit we;
        we = m_busy && req[m_owner] && !fifo_full;
        if (we) begin
            prod_data[m_owner] = prod_data[m_owner] + 8'd1;
            m_beats++;
        end
        if (!m_busy) begin
            if (req != '0) begin
                m_busy  = 1'b1;
                m_owner = rr_pick(req, m_last);
                m_beats = 0;
            end
        end else if ((we && m_beats == MB) || !req[m_owner]) begin
            m_last  = m_owner;
            m_beats = 0;
            if (req != '0) begin
                m_owner = rr_pick(req, m_last);
            end else begin
                m_busy  = 1'b0;
                m_owner = 0;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [N-1:0] eg;
        logic [W-1:0] ed;
        bit           ewe;
        eg  = m_busy ? (N'(1) << m_owner) : '0;
        ed  = m_busy ? prod_data[m_owner] : '0;
        ewe = m_busy && req[m_owner] && !fifo_full;
        check({tag, ".gnt"},   32'(gnt),          32'(eg));
        check({tag, ".wr_en"}, 32'(fifo_wr_en),   32'(ewe));
        check({tag, ".data"},  32'(fifo_wr_data), 32'(ed));
        check({tag, ".owner"}, 32'(owner_id),     m_busy ? 32'(m_owner) : 32'd0);
        check({tag, ".busy"},  32'(busy),         32'(m_busy));
    endtask

    task automatic cycleBody(input logic [N-1:0] r, input logic f, input string tag);
        req       = r;
        fifo_full = f;
        for (int k = 0; k < N; k++) data_in[k*W +: W] = prod_data[k];
        #1;
        checkOutput(tag);
        if (fifo_wr_en === 1'b1) begin
            obs_log.push_back(fifo_wr_data);
            obs_own.push_back(int'(owner_id));
        end
        modelStep();
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic f, input string tag);
        @(negedge clk);
        cycleBody(r, f, tag);
    endtask

    task automatic releaseReset(input logic [N-1:0] r, input string tag);
        @(negedge clk);
        rst = 1'b0;
        cycleBody(r, 1'b0, tag);
    endtask

    // Raises rst between clock edges and expects every output to clear at once.
    task automatic midReset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, ".gnt"},   32'(gnt),          32'd0);
        check({tag, ".wr_en"}, 32'(fifo_wr_en),   32'd0);
        check({tag, ".busy"},  32'(busy),         32'd0);
        check({tag, ".owner"}, 32'(owner_id),     32'd0);
        check({tag, ".data"},  32'(fifo_wr_data), 32'd0);
        modelReset();
        obs_log.delete();
        obs_own.delete();
    endtask

    initial begin
        int cnt;
        rst       = 1'b1;
        req       = '0;
        fifo_full = 1'b0;
        for (int k = 0; k < N; k++) prod_data[k] = '0;
        data_in   = '0;
        modelReset();
        #3;
        checkOutput("por");

        releaseReset(4'b1111, "rst_rel");
        for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 1'b0, "rst_pre");
        midReset("rst_mid");
        releaseReset(4'b1111, "rst_rel2");
        applyStimulus(4'b1111, 1'b0, "rst_first");
        check("rst_first_gnt", 32'(gnt), 32'h1);

        $display("[TB] single producer");
        midReset("single_rst");
        prod_data[0] = 8'd1;
        releaseReset(4'b0001, "single");
        for (int i = 0; i < 6; i++) applyStimulus(4'b0001, 1'b0, "single");
        applyStimulus(4'b0000, 1'b0, "single_drop");
        applyStimulus(4'b0000, 1'b0, "single_idle");
        check("single_idle_gnt", 32'(gnt), 32'd0);
        check("single_count", 32'(obs_log.size()), 32'd6);
        for (int i = 0; i < obs_log.size() && i < 6; i++)
            check("single_data", 32'(obs_log[i]), 32'(i + 1));

        $display("[TB] full contention");
        midReset("cont_rst");
        releaseReset(4'b1111, "cont");
        for (int i = 0; i < 16; i++) applyStimulus(4'b1111, 1'b0, "cont");
        check("cont_writes", 32'(obs_own.size()), 32'd16);
        for (int i = 0; i < obs_own.size() && i < 16; i++)
            check("cont_order", 32'(obs_own[i]), 32'((i / 4) % 4));
        applyStimulus(4'b1111, 1'b0, "cont_wrap");
        check("cont_wrap_gnt", 32'(gnt), 32'h1);

        $display("[TB] full stall");
        midReset("stall_rst");
        prod_data[2] = 8'h20;
        releaseReset(4'b0100, "stall");
        for (int i = 0; i < 2; i++) applyStimulus(4'b0100, 1'b0, "stall_pre");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0100, 1'b1, "stall_full");
            check("stall_gnt", 32'(gnt), 32'h4);
            check("stall_wr_en", 32'(fifo_wr_en), 32'd0);
        end
        for (int i = 0; i < 2; i++) applyStimulus(4'b0100, 1'b0, "stall_post");
        applyStimulus(4'b0000, 1'b0, "stall_drop");
        check("stall_writes", 32'(obs_log.size()), 32'd4);

        $display("[TB] early release");
        midReset("early_rst");
        releaseReset(4'b0110, "early");
        for (int i = 0; i < 2; i++) applyStimulus(4'b0110, 1'b0, "early_p1");
        applyStimulus(4'b0100, 1'b0, "early_drop");
        applyStimulus(4'b0100, 1'b0, "early_hand");
        check("early_hand_gnt", 32'(gnt), 32'h4);
        check("early_hand_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0100, 1'b0, "early_p2");
        applyStimulus(4'b0000, 1'b0, "early_end");
        cnt = 0;
        foreach (obs_own[i]) if (obs_own[i] == 2) cnt++;
        check("early_p2_beats", 32'(cnt), 32'd4);

        $display("[TB] reset mid-burst");
        midReset("mb_rst0");
        releaseReset(4'b1000, "mb");
        applyStimulus(4'b1000, 1'b0, "mb_beat1");
        applyStimulus(4'b1000, 1'b0, "mb_beat2");
        midReset("mb_rst");
        releaseReset(4'b1001, "mb_rel");
        applyStimulus(4'b1001, 1'b0, "mb_first");
        check("mb_first_gnt", 32'(gnt), 32'h1);

        $display("[TB] random traffic");
        for (int k = 0; k < N; k++) prod_data[k] = W'($urandom);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                midReset("rnd_rst");
                releaseReset(N'($urandom), "rnd_rel");
            end else begin
                applyStimulus(N'($urandom), ($urandom_range(0, 3) == 0), "rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's synchronous FIFO among N producers.
- Grants one producer at a time and holds the grant for a burst of up to MAX_BURST accepted beats, or until that producer drops its request.
- Stalls cleanly on FIFO full.
- Sits between producer blocks and the FIFO wr_en/wr_data/full interface, in the same clock domain as the FIFO.

Parameters:
- N, 4, number of requesters (N >= 2).
- W, 8, data width; matches the FIFO wr_data width.
- MAX_BURST, 4, maximum accepted beats per grant (>= 1).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  N  per-producer request; bit k high means producer k has valid data on its data slice.
- data_in  input  N*W  producer data, flattened; slice k is bits [k*W +: W].
- fifo_full  input  1  full flag from the FIFO.
- gnt  output  N  registered one-hot grant; all zeros when idle.
- fifo_wr_en  output  1  combinational FIFO write strobe.
- fifo_wr_data  output  W  data slice of the granted producer; 0 when idle.
- owner_id  output  clog2(N)  index of the current owner; 0 when idle.
- busy  output  1  high while in state BUSY.

Behaviour:
- Reset, asynchronous and applied immediately:
  - state=IDLE; gnt=0; beat_cnt=0; busy=0; owner_id=0; fifo_wr_en=0; fifo_wr_data=0.
  - Round-robin pointer last=N-1, so producer 0 has top priority after reset.
- accept = busy & req[owner] & ~fifo_full.
- fifo_wr_en = accept, combinational in the same cycle. fifo_wr_data = data_in[owner] whenever busy.
- A producer advances its data only on a cycle where gnt[k] & fifo_wr_en.
- Round-robin pick: search req starting at index last+1, wrapping modulo N. The first set bit wins. The current owner is eligible again only after all other indices have been searched.
- IDLE:
  - If |req, go to BUSY next edge; gnt = one-hot(pick); beat_cnt = 0.
  - There is no write in the granting cycle, so first-grant latency is 1 cycle after req.
- BUSY, each edge:
  - On accept, beat_cnt += 1.
  - release = (accept & beat_cnt == MAX_BURST-1) | ~req[owner].
  - On release: last = owner. If any req bit (evaluated with the owner's bit masked when ~req[owner]) gives a pick, hand off directly to that pick next edge with beat_cnt = 0 and no idle bubble. Otherwise go to IDLE with gnt=0.
  - A sole requester reaching the burst limit is re-granted immediately with beat_cnt cleared.
- fifo_full in BUSY:
  - accept=0; gnt, owner and beat_cnt are frozen.
  - A full-stall cycle never counts toward MAX_BURST.
- Owner drops req while fifo_full: release still occurs, with no write in that cycle.
- Requests from non-owners never preempt a burst.
- Reset asserted mid-burst: state and outputs clear immediately. No partial write is issued after rst rises.
- beat_cnt width is clog2(MAX_BURST), with a minimum of 1 bit. It never exceeds MAX_BURST-1.

Test Plan (N=4, W=8, MAX_BURST=4):
- Reset: assert rst mid-cycle with all req=1 -> gnt=0000, fifo_wr_en=0, busy=0, owner_id=0 immediately. After release, the first grant is 0001.
- Single producer: req=0001 held, data 1..6 advancing on accept -> one cycle later gnt=0001.
  - FIFO receives 1,2,3,4.
  - Re-grant to 0001 with no bubble, then 5,6.
  - req drops -> gnt=0000, busy=0.
- Full contention: req=1111 continuous, fifo_full=0 -> grant order 0001,0010,0100,1000,0001.
  - Exactly 4 writes per grant.
  - 16 writes in 17 cycles after the first req.
- Full stall: producer 2 owns, fifo_full=1 for 3 cycles after its 2nd beat -> fifo_wr_en=0, gnt=0100 and beat_cnt=2 held. Burst completes with 4 total writes.
- Early release: req=0110, producer 1 owner drops req after 2 beats -> next edge gnt=0100 with no idle cycle. Producer 2 then gets a full 4-beat burst.
- Reset mid-burst: producer 3 owns after beat 1 -> rst pulse clears gnt to 0000 asynchronously. After release with req=1001, grant goes to 0001 first (pointer reset).
